// File: rtl/usr_pkg.sv
// usr_pkg: mode encodings and shift-op decode for universal_shift_reg.
// Honours the ROTATE_EN macro: when undefined, ROR/ROL are not shift ops.
package usr_pkg;
    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHR   = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_LOAD  = 3'b011;
    localparam logic [2:0] MODE_CLEAR = 3'b100;
    localparam logic [2:0] MODE_ROR   = 3'b101;
    localparam logic [2:0] MODE_ROL   = 3'b110;

    function automatic logic is_shift(input logic [2:0] mode);
`ifdef ROTATE_EN
        return mode inside {MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL};
`else
        return mode inside {MODE_SHR, MODE_SHL};
`endif
    endfunction
endpackage

// File: rtl/universal_shift_reg_if.sv
// universal_shift_reg_if: control, data and status bundle of the shift register.
interface universal_shift_reg_if #(parameter int N = 4);
    localparam int CNT_W = $clog2(N + 1);
    logic [2:0]       mode;
    logic             serial_in_l;
    logic             serial_in_r;
    logic [N-1:0]     I;
    logic [N-1:0]     q;
    logic             serial_out_r;
    logic             serial_out_l;
    logic [CNT_W-1:0] shift_cnt;
    logic             done;
    modport master (output mode, serial_in_l, serial_in_r, I,
                    input q, serial_out_r, serial_out_l, shift_cnt, done);
    modport slave  (input mode, serial_in_l, serial_in_r, I,
                    output q, serial_out_r, serial_out_l, shift_cnt, done);
endinterface

// File: rtl/usr_shift_counter.sv
// usr_shift_counter: counts shifts since last LOAD/CLEAR, saturating at N,
// and pulses done on the shift that reaches N.
module usr_shift_counter #(
    parameter int N = 4,
    localparam int CNT_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             done
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    always_comb begin
        cnt_d  = clr ? '0 : (inc && cnt_q != CNT_W'(N)) ? cnt_q + 1'b1 : cnt_q;
        done_d = !clr && inc && cnt_q == CNT_W'(N - 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign shift_cnt = cnt_q;
    assign done      = done_q;
endmodule

// File: rtl/universal_shift_reg.sv
// universal_shift_reg: N-bit hold/shift/load/clear register with shift counter.
// Define ROTATE_EN to enable ROR/ROL modes; otherwise they act as HOLD.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int N = 4
) (
    input logic                  clk,
    input logic                  reset,
    universal_shift_reg_if.slave bus
);
    logic [N-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        case (bus.mode)
            MODE_SHR:   q_d = {bus.serial_in_l, q_q[N-1:1]};
            MODE_SHL:   q_d = {q_q[N-2:0], bus.serial_in_r};
            MODE_LOAD:  q_d = bus.I;
            MODE_CLEAR: q_d = '0;
`ifdef ROTATE_EN
            MODE_ROR:   q_d = {q_q[0], q_q[N-1:1]};
            MODE_ROL:   q_d = {q_q[N-2:0], q_q[N-1]};
`endif
            default:    q_d = q_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) q_q <= '0;
        else       q_q <= q_d;
    end

    assign bus.q            = q_q;
    assign bus.serial_out_r = q_q[0];
    assign bus.serial_out_l = q_q[N-1];

    usr_shift_counter #(.N(N)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (bus.mode == MODE_LOAD || bus.mode == MODE_CLEAR),
        .inc      (is_shift(bus.mode)),
        .shift_cnt(bus.shift_cnt),
        .done     (bus.done)
    );
endmodule

// File: tb/tb_universal_shift_reg.sv
// tb_universal_shift_reg: table-driven directed checks of universal_shift_reg (N=4).
module tb_universal_shift_reg;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    universal_shift_reg_if #(.N(4)) bus ();
    universal_shift_reg #(.N(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic       rst;
        logic [2:0] mode;
        logic       sl;
        logic       sr;
        logic [3:0] i;
        logic [3:0] eq;
        logic [2:0] ec;
        logic       ed;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input string name);
        reset           = v.rst;
        bus.mode        = v.mode;
        bus.serial_in_l = v.sl;
        bus.serial_in_r = v.sr;
        bus.I           = v.i;
        @(posedge clk);
        #1;
        chk({name, " q"}, bus.q, v.eq);
        chk({name, " cnt"}, {1'b0, bus.shift_cnt}, {1'b0, v.ec});
        chk({name, " done"}, {3'b0, bus.done}, {3'b0, v.ed});
        chk({name, " sout_r"}, {3'b0, bus.serial_out_r}, {3'b0, v.eq[0]});
        chk({name, " sout_l"}, {3'b0, bus.serial_out_l}, {3'b0, v.eq[3]});
    endtask

    initial begin
        vec_t v;
        logic [3:0] rq;
        reset = 1'b1;
        bus.mode = 3'b000;
        bus.serial_in_l = 1'b0;
        bus.serial_in_r = 1'b0;
        bus.I = 4'h0;
        // rst mode sl sr I exp_q exp_cnt exp_done
        vecs.push_back('{1, 3'b011, 0, 0, 4'hF, 4'b0000, 0, 0});  // reset beats LOAD
        vecs.push_back('{0, 3'b011, 0, 0, 4'hB, 4'b1011, 0, 0});
        vecs.push_back('{0, 3'b001, 0, 0, 4'h0, 4'b0101, 1, 0});
        vecs.push_back('{0, 3'b001, 0, 0, 4'h0, 4'b0010, 2, 0});
        vecs.push_back('{0, 3'b001, 0, 0, 4'h0, 4'b0001, 3, 0});
        vecs.push_back('{0, 3'b001, 0, 0, 4'h0, 4'b0000, 4, 1});
        vecs.push_back('{0, 3'b000, 0, 0, 4'h0, 4'b0000, 4, 0});
        vecs.push_back('{0, 3'b011, 0, 0, 4'h1, 4'b0001, 0, 0});
        vecs.push_back('{0, 3'b010, 0, 1, 4'h0, 4'b0011, 1, 0});
        vecs.push_back('{0, 3'b010, 0, 1, 4'h0, 4'b0111, 2, 0});
        vecs.push_back('{0, 3'b010, 0, 1, 4'h0, 4'b1111, 3, 0});
        vecs.push_back('{0, 3'b011, 0, 0, 4'hC, 4'b1100, 0, 0});
        vecs.push_back('{0, 3'b001, 0, 0, 4'h0, 4'b0110, 1, 0});
        vecs.push_back('{0, 3'b001, 0, 0, 4'h0, 4'b0011, 2, 0});
        vecs.push_back('{1, 3'b001, 1, 0, 4'h0, 4'b0000, 0, 0});  // reset mid-shift
        vecs.push_back('{0, 3'b001, 1, 0, 4'h0, 4'b1000, 1, 0});
        vecs.push_back('{0, 3'b100, 0, 0, 4'h0, 4'b0000, 0, 0});
        vecs.push_back('{0, 3'b011, 0, 0, 4'hB, 4'b1011, 0, 0});
        vecs.push_back('{0, 3'b001, 0, 0, 4'h0, 4'b0101, 1, 0});
        vecs.push_back('{0, 3'b001, 0, 0, 4'h0, 4'b0010, 2, 0});
        vecs.push_back('{0, 3'b001, 0, 0, 4'h0, 4'b0001, 3, 0});
        vecs.push_back('{0, 3'b011, 0, 0, 4'h5, 4'b0101, 0, 0});  // LOAD wins
        vecs.push_back('{0, 3'b001, 1, 0, 4'h0, 4'b1010, 1, 0});
        vecs.push_back('{0, 3'b001, 1, 0, 4'h0, 4'b1101, 2, 0});
        vecs.push_back('{0, 3'b001, 1, 0, 4'h0, 4'b1110, 3, 0});
        vecs.push_back('{0, 3'b001, 1, 0, 4'h0, 4'b1111, 4, 1});
        vecs.push_back('{0, 3'b001, 0, 0, 4'h0, 4'b0111, 4, 0});
        vecs.push_back('{0, 3'b010, 0, 0, 4'h0, 4'b1110, 4, 0});
        vecs.push_back('{0, 3'b111, 1, 1, 4'h0, 4'b1110, 4, 0});  // reserved = HOLD
        foreach (vecs[k]) step(vecs[k], $sformatf("vec%0d", k));

        // Rotate corner case, hand-sequenced: LOAD 1000 then four ROL
        step('{0, 3'b011, 0, 0, 4'h8, 4'b1000, 0, 0}, "rol_load");
        rq = 4'b1000;
        for (int k = 1; k <= 4; k++) begin
`ifdef ROTATE_EN
            rq = {rq[2:0], rq[3]};
            v = '{0, 3'b110, 1, 1, 4'h0, rq, 3'(k), k == 4};
`else
            v = '{0, 3'b110, 1, 1, 4'h0, 4'b1000, 0, 0};
`endif
            step(v, $sformatf("rol%0d", k));
        end
`ifdef ROTATE_EN
        step('{0, 3'b101, 0, 0, 4'h0, 4'b0100, 4, 0}, "ror_sat");
`else
        step('{0, 3'b101, 0, 0, 4'h0, 4'b1000, 0, 0}, "ror_hold");
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
